cu_wb: RTL and testbench

CU_WB -- requirements
Module: cu_wb

---
 rtl/cu_pkg.sv | 14 +
 rtl/cu_wb.sv | 133 +++++++++++++
 tb/tb_cu_wb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the write-back control unit.
package cu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_COMMIT  = 2'd1,
    WB_RELEASE = 2'd2,
    WB_TRAP    = 2'd3
  } wb_state_t;

endpackage : cu_pkg

// File: rtl/cu_wb.sv
// Write-back control unit: captures an execute-stage result on the rising
// edge of result_ready, commits it to the register file / PC for one cycle,
// then restarts the execute stage. Errors park the unit in TRAP.
module cu_wb
  import cu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic            soc_clk,
  input  logic            WB_reset_n,
  input  logic [XLEN-1:0] result_data,
  input  logic            result_ready,
  input  logic            overflow_flag,
  input  logic            zero_flag,
  input  logic            condition_met_flag,
  input  logic            error_flag,
  input  logic [RA_W-1:0] rd_addr,
  input  logic            wb_en,
  input  logic            is_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_clr,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  output logic            EX_reset,
  output logic            wb_done,
  output logic            trap,
  output logic            ovf_sticky
);

  wb_state_t       state_q, state_d;
  logic            rdy_q;
  logic            rise;
  logic            zero_q, zero_d;
  logic            ovf_d;
  logic            rf_we_d, pc_load_d, ex_reset_d, wb_done_d, trap_d;
  logic [RA_W-1:0] rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_d, pc_next_d;

  assign rise = result_ready & ~rdy_q;

  // Outputs are registered: each is computed for the state being entered,
  // so the captured operands are latched straight into the output flops.
  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    pc_load_d  = 1'b0;
    pc_next_d  = '0;
    ex_reset_d = 1'b0;
    wb_done_d  = 1'b0;
    trap_d     = 1'b0;
    ovf_d      = ovf_sticky;
    zero_d     = zero_q;
    case (state_q)
      WB_IDLE: begin
        if (rise) begin
          ovf_d  = ovf_sticky | overflow_flag;
          zero_d = zero_flag;
          if (error_flag) begin
            state_d    = WB_TRAP;
            trap_d     = 1'b1;
            ex_reset_d = 1'b1;
          end else begin
            state_d    = WB_COMMIT;
            rf_we_d    = wb_en && (rd_addr != '0);
            rf_waddr_d = rd_addr;
            rf_wdata_d = result_data;
            if (is_branch && condition_met_flag) begin
              pc_load_d = 1'b1;
              pc_next_d = branch_target;
            end
          end
        end
      end
      WB_COMMIT: begin
        state_d    = WB_RELEASE;
        ex_reset_d = 1'b1;
        wb_done_d  = 1'b1;
      end
      WB_RELEASE: begin
        state_d = WB_IDLE;
      end
      WB_TRAP: begin
        if (trap_clr) begin
          state_d = WB_IDLE;
        end else begin
          trap_d     = 1'b1;
          ex_reset_d = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State, edge detector and output registers. The edge detector keeps
  // tracking result_ready while busy, so a level still high after RELEASE
  // is not mistaken for a new result; once it drops, the next rise is seen.
  always_ff @(posedge soc_clk or negedge WB_reset_n) begin
    if (!WB_reset_n) begin
      state_q    <= WB_IDLE;
      rdy_q      <= 1'b0;
      zero_q     <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pc_load    <= 1'b0;
      pc_next    <= '0;
      EX_reset   <= 1'b0;
      wb_done    <= 1'b0;
      trap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= result_ready;
      zero_q     <= zero_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      pc_load    <= pc_load_d;
      pc_next    <= pc_next_d;
      EX_reset   <= ex_reset_d;
      wb_done    <= wb_done_d;
      trap       <= trap_d;
      ovf_sticky <= ovf_d;
    end
  end

endmodule : cu_wb

// File: tb/tb_cu_wb.sv
// Self-checking bench for cu_wb: table of operations with a scoreboard
// monitor, plus hand sequences for latency, trap, level hold and reset.
module tb_cu_wb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  logic            soc_clk = 1'b0;
  logic            WB_reset_n = 1'b0;
  logic [XLEN-1:0] result_data = '0;
  logic            result_ready = 1'b0;
  logic            overflow_flag = 1'b0;
  logic            zero_flag = 1'b0;
  logic            condition_met_flag = 1'b0;
  logic            error_flag = 1'b0;
  logic [RA_W-1:0] rd_addr = '0;
  logic            wb_en = 1'b0;
  logic            is_branch = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic            trap_clr = 1'b0;
  logic            rf_we, pc_load, EX_reset, wb_done, trap, ovf_sticky;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata, pc_next;

  cu_wb #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .soc_clk(soc_clk), .WB_reset_n(WB_reset_n),
    .result_data(result_data), .result_ready(result_ready),
    .overflow_flag(overflow_flag), .zero_flag(zero_flag),
    .condition_met_flag(condition_met_flag), .error_flag(error_flag),
    .rd_addr(rd_addr), .wb_en(wb_en), .is_branch(is_branch),
    .branch_target(branch_target), .trap_clr(trap_clr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_next(pc_next), .EX_reset(EX_reset),
    .wb_done(wb_done), .trap(trap), .ovf_sticky(ovf_sticky)
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [RA_W-1:0] rd;
    logic            wen;
    logic            br;
    logic [XLEN-1:0] tgt;
    logic            cond;
    logic            ovf;
    logic            exp_we;
    logic            exp_pl;
  } vec_t;

  typedef struct {
    logic            is_trap;
    logic            we;
    logic [RA_W-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic            pl;
    logic [XLEN-1:0] pnext;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: previous-cycle samples let the RELEASE pulse validate COMMIT.
  logic            p_we = 1'b0, p_pl = 1'b0, p_trap = 1'b0;
  logic [RA_W-1:0] p_waddr = '0;
  logic [XLEN-1:0] p_wdata = '0, p_pnext = '0;

  always @(posedge soc_clk) begin
    exp_t e;
    #1;
    if (wb_done) begin
      done_cnt++;
      if (sb.size() == 0) check("sb_unexpected_done", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        check("done_kind", {63'd0, e.is_trap}, 64'd0);
        check("commit_rf_we", {63'd0, p_we}, {63'd0, e.we});
        if (e.we) begin
          check("commit_waddr", 64'(p_waddr), 64'(e.waddr));
          check("commit_wdata", 64'(p_wdata), 64'(e.wdata));
        end
        check("commit_pc_load", {63'd0, p_pl}, {63'd0, e.pl});
        if (e.pl) check("commit_pc_next", 64'(p_pnext), 64'(e.pnext));
        check("release_ex_reset", {63'd0, EX_reset}, 64'd1);
        check("release_rf_we_low", {63'd0, rf_we}, 64'd0);
      end
    end
    if (trap && !p_trap) begin
      if (sb.size() == 0) check("sb_unexpected_trap", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        check("trap_kind", {63'd0, e.is_trap}, 64'd1);
        check("trap_rf_we", {63'd0, rf_we}, 64'd0);
        check("trap_pc_load", {63'd0, pc_load}, 64'd0);
        check("trap_ex_reset", {63'd0, EX_reset}, 64'd1);
      end
    end
    if (rf_we && p_we) check("rf_we_pulse_width", 64'd2, 64'd1);
    p_we = rf_we; p_waddr = rf_waddr; p_wdata = rf_wdata;
    p_pl = pc_load; p_pnext = pc_next; p_trap = trap;
  end

  task automatic drive(input vec_t v);
    result_data = v.data; rd_addr = v.rd; wb_en = v.wen; is_branch = v.br;
    branch_target = v.tgt; condition_met_flag = v.cond; overflow_flag = v.ovf;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.is_trap = 1'b0; e.we = v.exp_we; e.waddr = v.rd; e.wdata = v.data;
    e.pl = v.exp_pl; e.pnext = v.tgt;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int prev, input string name);
    for (int i = 0; i < 10 && done_cnt == prev; i++) @(negedge soc_clk);
    check(name, 64'(done_cnt - prev), 64'd1);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, idle.
  task automatic run_vec(input vec_t v);
    int prev;
    drive(v);
    push_exp(v);
    prev = done_cnt;
    result_ready = 1'b1;
    wait_done(prev, "op_done_timeout");
    result_ready = 1'b0;
    overflow_flag = 1'b0;
    @(negedge soc_clk);
  endtask

  vec_t vt[8];
  vec_t v;
  int   c0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h0000_00AB, 5'd5,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0011, 5'd6,  1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[2] = '{32'h0000_0022, 5'd6,  1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'hFFFF_FFFF, 5'd0,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{32'h0000_1234, 5'd7,  1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5] = '{32'h0000_0333, 5'd3,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{32'h0000_0044, 5'd8,  1'b1, 1'b0, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state.
    #1;
    check("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("rst_ex_reset", {63'd0, EX_reset}, 64'd0);
    check("rst_trap", {63'd0, trap}, 64'd0);
    check("rst_ovf", {63'd0, ovf_sticky}, 64'd0);
    check("rst_pc_next", 64'(pc_next), 64'd0);
    @(negedge soc_clk); @(negedge soc_clk);
    WB_reset_n = 1'b1;
    @(negedge soc_clk);

    foreach (vt[i]) run_vec(vt[i]);

    // Explicit latency: rf_we one edge after capture, EX_reset the next.
    drive(vt[0]); push_exp(vt[0]);
    result_ready = 1'b1;
    @(posedge soc_clk); #2;
    check("lat_rf_we", {63'd0, rf_we}, 64'd1);
    check("lat_waddr", 64'(rf_waddr), 64'd5);
    check("lat_wdata", 64'(rf_wdata), 64'hAB);
    check("lat_ex_reset_low", {63'd0, EX_reset}, 64'd0);
    @(posedge soc_clk); #2;
    check("lat_ex_reset", {63'd0, EX_reset}, 64'd1);
    check("lat_wb_done", {63'd0, wb_done}, 64'd1);
    @(negedge soc_clk); result_ready = 1'b0;
    @(negedge soc_clk);
    check("lat_idle_ex_reset", {63'd0, EX_reset}, 64'd0);

    // trap_clr outside TRAP has no effect.
    trap_clr = 1'b1;
    run_vec(vt[6]);
    trap_clr = 1'b0;
    check("clr_ignored_trap", {63'd0, trap}, 64'd0);

    // Error at capture parks in TRAP until trap_clr.
    begin
      exp_t e;
      e = '{1'b1, 1'b0, '0, '0, 1'b0, '0};
      sb.push_back(e);
    end
    drive(vt[4]); error_flag = 1'b1; result_ready = 1'b1;
    @(negedge soc_clk);
    check("trap_set", {63'd0, trap}, 64'd1);
    result_ready = 1'b0; error_flag = 1'b0;
    repeat (3) @(negedge soc_clk);
    check("trap_held", {63'd0, trap}, 64'd1);
    check("trap_ex_held", {63'd0, EX_reset}, 64'd1);
    check("trap_no_we", {63'd0, rf_we}, 64'd0);
    trap_clr = 1'b1;
    @(negedge soc_clk);
    trap_clr = 1'b0;
    check("trap_cleared", {63'd0, trap}, 64'd0);
    check("trap_ex_cleared", {63'd0, EX_reset}, 64'd0);
    check("trap_done_none", 64'(done_cnt), 64'(c0 + 10));
    @(negedge soc_clk);

    // Level held 10 cycles: one commit, overflow sets sticky flag.
    v = '{32'h0000_0099, 5'd9, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    drive(v); push_exp(v);
    c0 = done_cnt;
    result_ready = 1'b1;
    repeat (10) @(negedge soc_clk);
    check("hold_one_commit", 64'(done_cnt - c0), 64'd1);
    check("ovf_set", {63'd0, ovf_sticky}, 64'd1);
    result_ready = 1'b0; overflow_flag = 1'b0;
    @(negedge soc_clk);
    run_vec(vt[5]);
    check("ovf_sticky_kept", {63'd0, ovf_sticky}, 64'd1);

    // Asynchronous reset in the middle of COMMIT.
    drive(vt[6]); result_ready = 1'b1;
    @(posedge soc_clk); #2;
    check("mid_commit_we", {63'd0, rf_we}, 64'd1);
    WB_reset_n = 1'b0;
    #1;
    check("arst_rf_we", {63'd0, rf_we}, 64'd0);
    check("arst_wdata", 64'(rf_wdata), 64'd0);
    check("arst_ex_reset", {63'd0, EX_reset}, 64'd0);
    check("arst_ovf", {63'd0, ovf_sticky}, 64'd0);
    check("arst_pc_load", {63'd0, pc_load}, 64'd0);
    result_ready = 1'b0;
    @(negedge soc_clk); WB_reset_n = 1'b1;
    c0 = done_cnt;
    repeat (3) @(negedge soc_clk);
    check("arst_no_partial", 64'(done_cnt - c0), 64'd0);
    check("arst_no_we", {63'd0, rf_we}, 64'd0);

    // result_ready already high at reset release counts as an edge.
    WB_reset_n = 1'b0;
    v = '{32'h0000_0055, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(v); push_exp(v);
    result_ready = 1'b1;
    @(negedge soc_clk); WB_reset_n = 1'b1;
    c0 = done_cnt;
    @(posedge soc_clk); #2;
    check("rel_capture_we", {63'd0, rf_we}, 64'd1);
    wait_done(c0, "rel_done_timeout");
    result_ready = 1'b0;
    repeat (2) @(negedge soc_clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cu_wb
